// File: rtl/montgomery_product_if.sv
// rtl/montgomery_product_if.sv - request/response bundle for the Montgomery product engine
interface montgomery_product_if #(
  parameter int WIDTH = 256
);
  logic             start;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, N, a, b,
    input  result, done, busy
  );

  modport slave (
    input  start, N, a, b,
    output result, done, busy
  );
endinterface

// File: rtl/montgomery_product.sv
// rtl/montgomery_product.sv - radix-2 iterative Montgomery multiplier, a*b*2^-WIDTH mod N
module montgomery_product #(
  parameter int WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  montgomery_product_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH+1:0] m;
  logic [CNT_W-1:0] i;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH+1:0] s_add;
  logic [WIDTH+1:0] s_odd;
  logic [WIDTH-1:0] m_sub;
  logic             accept;
  logic             last_iter;

  // busy_q is still high in the done cycle, which keeps a start there from being taken
  assign accept    = (state == IDLE) && !busy_q && bus.start;
  assign last_iter = (i == LAST_ITER);

  // a_reg is shifted right each iteration, so bit 0 is always multiplier bit i
  assign s_add = m + ({(WIDTH+2){a_reg[0]}} & {2'b00, b_reg});
  assign s_odd = s_add[0] ? (s_add + {2'b00, n_reg}) : s_add;
  assign m_sub = m[WIDTH-1:0] - n_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      m        <= '0;
      i        <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            n_reg  <= bus.N;
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            m      <= '0;
            i      <= '0;
            busy_q <= 1'b1;
          end else if (done_q) begin
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          m     <= s_odd >> 1;
          a_reg <= a_reg >> 1;
          i     <= i + CNT_W'(1);
        end
        FINAL: begin
          result_q <= (m >= {2'b00, n_reg}) ? m_sub : m[WIDTH-1:0];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_montgomery_product.sv
// tb/tb_montgomery_product.sv - scoreboard bench for montgomery_product at WIDTH=4 and WIDTH=256
module tb_montgomery_product;

  localparam int W_S = 4;
  localparam int W_L = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  montgomery_product_if #(.WIDTH(W_S)) bus_s ();
  montgomery_product_if #(.WIDTH(W_L)) bus_l ();

  montgomery_product #(.WIDTH(W_S)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  montgomery_product #(.WIDTH(W_L)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  int vectors_applied = 0;
  int miscompares     = 0;
  logic [255:0] exp_q_s[$];
  logic [255:0] exp_q_l[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reduce a*b first, then divide by two mod N w times
  function automatic logic [255:0] mont_ref(input logic [255:0] n, input logic [255:0] a,
                                            input logic [255:0] b, input int w);
    logic [256:0] x;
    x = 257'((512'(a) * 512'(b)) % 512'(n));
    for (int k = 0; k < w; k++) begin
      if (x[0]) x = x + 257'(n);
      x = x >> 1;
    end
    return 256'(x);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [255:0] n,
                       input logic [255:0] a, input logic [255:0] b);
    if (sel == 0) begin
      bus_s.start = st;
      bus_s.N     = W_S'(n);
      bus_s.a     = W_S'(a);
      bus_s.b     = W_S'(b);
    end else begin
      bus_l.start = st;
      bus_l.N     = n;
      bus_l.a     = a;
      bus_l.b     = b;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus_s.done : bus_l.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus_s.busy : bus_l.busy;
  endfunction

  task automatic push_exp(input int sel, input logic [255:0] e);
    if (sel == 0) exp_q_s.push_back(e);
    else          exp_q_l.push_back(e);
  endtask

  // Called #1 after the accepting edge; leaves the bench #1 after the edge that drops busy
  task automatic wait_done(input int sel, input string tag);
    int w;
    int cnt;
    w   = (sel == 0) ? W_S : W_L;
    cnt = 0;
    while (!get_done(sel) && cnt < w + 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq({tag, "_latency"}, 256'(cnt), 256'(w + 1));
    @(posedge clk); #1;
    check_eq({tag, "_busy_fall"}, 256'(get_busy(sel)), 256'(0));
    check_eq({tag, "_done_fall"}, 256'(get_done(sel)), 256'(0));
  endtask

  task automatic run_op(input int sel, input logic [255:0] n, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] e, input string tag);
    @(posedge clk); #1;
    drive(sel, 1'b1, n, a, b);
    push_exp(sel, e);
    @(posedge clk); #1;
    drive(sel, 1'b0, n, a, b);
    check_eq({tag, "_busy_rise"}, 256'(get_busy(sel)), 256'(1));
    wait_done(sel, tag);
  endtask

  always @(negedge clk) begin
    if (bus_s.done) begin
      check_eq("s_busy_at_done", 256'(bus_s.busy), 256'(1));
      if (exp_q_s.size() == 0) check_eq("s_spurious_done", 256'(1), 256'(0));
      else                     check_eq("s_result", 256'(bus_s.result), exp_q_s.pop_front());
    end
    if (bus_l.done) begin
      check_eq("l_busy_at_done", 256'(bus_l.busy), 256'(1));
      if (exp_q_l.size() == 0) check_eq("l_spurious_done", 256'(1), 256'(0));
      else                     check_eq("l_result", bus_l.result, exp_q_l.pop_front());
    end
  end

  initial begin
    logic [255:0] n;
    logic [255:0] a;
    logic [255:0] b;
    int           cnt;

    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);

    // Reset held with random activity on the inputs
    repeat (5) begin
      @(posedge clk); #1;
      drive(0, 1'($urandom), rand256(), rand256(), rand256());
      drive(1, 1'($urandom), rand256(), rand256(), rand256());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("rst_s_busy", 256'(bus_s.busy), 256'(0));
      check_eq("rst_s_done", 256'(bus_s.done), 256'(0));
      check_eq("rst_s_result", 256'(bus_s.result), 256'(0));
      check_eq("rst_l_busy", 256'(bus_l.busy), 256'(0));
      check_eq("rst_l_done", 256'(bus_l.done), 256'(0));
      check_eq("rst_l_result", bus_l.result, 256'(0));
    end

    // Small-width directed: R=16, R^-1 mod 13 = 9
    run_op(0, 256'd13, 256'd5, 256'd7, 256'd3, "s_5x7");
    run_op(0, 256'd13, 256'd1, 256'd1, 256'd9, "s_1x1");
    run_op(0, 256'd13, 256'd0, 256'd12, 256'd0, "s_0x12");

    // Handshake: start held through the whole op and the done cycle, operands churn mid-op
    @(posedge clk); #1;
    drive(0, 1'b1, 256'd13, 256'd5, 256'd7);
    push_exp(0, 256'd3);
    @(posedge clk); #1;
    check_eq("hs_busy_rise", 256'(bus_s.busy), 256'(1));
    cnt = 0;
    while (!bus_s.done && cnt < W_S + 8) begin
      drive(0, 1'b1, 256'd11, 256'($urandom_range(0, 10)), 256'($urandom_range(0, 10)));
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("hs_latency", 256'(cnt), 256'(W_S + 1));
    drive(0, 1'b1, 256'd13, 256'd1, 256'd1);
    @(posedge clk); #1;
    check_eq("hs_done_cycle_start_ignored", 256'(bus_s.busy), 256'(0));
    push_exp(0, 256'd9);
    @(posedge clk); #1;
    drive(0, 1'b0, 256'd13, 256'd1, 256'd1);
    check_eq("hs_first_idle_accept", 256'(bus_s.busy), 256'(1));
    wait_done(0, "hs_second");

    // Identity at full width: a = R mod N maps b back to itself
    n = (256'd1 << 255) + 256'h1D;
    a = 256'((257'd1 << 256) % 257'(n));
    run_op(1, n, a, 256'h1234, 256'h1234, "l_identity");
    run_op(1, n, n - 256'd1, n - 256'd1, mont_ref(n, n - 256'd1, n - 256'd1, W_L), "l_nm1_sq");

    // Asynchronous abort around iteration 100
    n = rand256() | 256'd1;
    a = rand256() % n;
    b = rand256() % n;
    @(posedge clk); #1;
    drive(1, 1'b1, n, a, b);
    push_exp(1, mont_ref(n, a, b, W_L));
    @(posedge clk); #1;
    drive(1, 1'b0, n, a, b);
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(exp_q_l.pop_back());
    #1;
    check_eq("abort_busy", 256'(bus_l.busy), 256'(0));
    check_eq("abort_done", 256'(bus_l.done), 256'(0));
    check_eq("abort_result", bus_l.result, 256'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W_L + 4) begin
      @(negedge clk);
      check_eq("abort_no_done", 256'(bus_l.done), 256'(0));
    end
    run_op(1, n, a, b, mont_ref(n, a, b, W_L), "l_after_abort");

    // Random regression
    for (int k = 0; k < 100; k++) begin
      n = 256'($urandom_range(1, 7) * 2 + 1);
      a = 256'($urandom_range(0, 32'(n) - 1));
      b = 256'($urandom_range(0, 32'(n) - 1));
      run_op(0, n, a, b, mont_ref(n, a, b, W_S), "s_rand");
    end
    for (int k = 0; k < 150; k++) begin
      n = rand256() | 256'd1;
      if (n == 256'd1) n = 256'd3;
      a = rand256() % n;
      b = rand256() % n;
      run_op(1, n, a, b, mont_ref(n, a, b, W_L), "l_rand");
    end

    repeat (4) @(posedge clk);
    check_eq("s_queue_drained", 256'(exp_q_s.size()), 256'(0));
    check_eq("l_queue_drained", 256'(exp_q_l.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
